// File: rtl/router_vc_pkg.sv
//------------------------------------------------------------------------------
// router_vc_pkg : shared VC-router definitions (arbiter state encoding,
//                 clog2 and width-generic rotate helpers)
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package router_vc_pkg;

    localparam logic ARB_IDLE     = 1'b0;
    localparam logic ARB_LOCKED   = 1'b1;
    localparam int   RR_MAX_PORTS = 32;

    typedef enum logic [0:0] {
        S_IDLE   = ARB_IDLE,
        S_LOCKED = ARB_LOCKED
    } arb_state_t;

    // Never below 1 so a single-port arbiter still gets a legal pointer width.
    function automatic int rr_clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [RR_MAX_PORTS-1:0] rr_rotr(
        input logic [RR_MAX_PORTS-1:0] v,
        input int unsigned             sh,
        input int unsigned             n
    );
        logic [RR_MAX_PORTS-1:0] o;
        int unsigned             j;
        o = '0;
        for (int unsigned i = 0; i < n; i++) begin
            j = i + sh;
            if (j >= n) j = j - n;
            o[i] = v[j];
        end
        return o;
    endfunction

    function automatic logic [RR_MAX_PORTS-1:0] rr_rotl(
        input logic [RR_MAX_PORTS-1:0] v,
        input int unsigned             sh,
        input int unsigned             n
    );
        logic [RR_MAX_PORTS-1:0] o;
        int unsigned             j;
        o = '0;
        for (int unsigned i = 0; i < n; i++) begin
            j = i + sh;
            if (j >= n) j = j - n;
            o[j] = v[i];
        end
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_wormhole_arbiter_fpa.sv
//------------------------------------------------------------------------------
// rr_wormhole_arbiter_fpa : combinational fixed-priority arbiter, bit 0 wins
// Revision                : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_wormhole_arbiter_fpa #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_grant
);

    // Two's-complement trick isolates the lowest set bit.
    assign o_grant = i_req & (~i_req + WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/rr_wormhole_arbiter.sv
//------------------------------------------------------------------------------
// rr_wormhole_arbiter : round-robin output-port arbiter with wormhole lock.
//   Optional macro RR_RELEASE_ON_DROP_EN: also release when the granted
//   port's request drops while no flit fires.
// Revision            : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_wormhole_arbiter
    import router_vc_pkg::*;
#(
    parameter int NUM_ARBITER_PORTS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_ARBITER_PORTS-1:0] request_in,
    input  logic [NUM_ARBITER_PORTS-1:0] tail_in,
    input  logic                         fire_in,
    output logic [NUM_ARBITER_PORTS-1:0] grant_out,
    output logic                         grant_valid_out,
    output logic                         locked_out
);

    localparam int PTR_WIDTH = rr_clog2(NUM_ARBITER_PORTS);

    arb_state_t                   r_state, w_state_nxt;
    logic [NUM_ARBITER_PORTS-1:0] r_grant, w_grant_nxt;
    logic                         r_grant_valid;
    logic [PTR_WIDTH-1:0]         r_ptr, w_ptr_nxt;

    logic [PTR_WIDTH-1:0]         w_idx, w_rel_ptr, w_arb_ptr;
    logic                         w_tail_rel, w_drop_rel, w_release;
    logic [NUM_ARBITER_PORTS-1:0] w_rot, w_fpa, w_winner;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_ARBITER_PORTS; i++) begin
            if (r_grant[i]) w_idx = PTR_WIDTH'(i);
        end
    end

    assign w_rel_ptr  = (w_idx == PTR_WIDTH'(NUM_ARBITER_PORTS - 1)) ? '0 : w_idx + 1'b1;
    assign w_tail_rel = fire_in & |(r_grant & tail_in);
`ifdef RR_RELEASE_ON_DROP_EN
    assign w_drop_rel = ~fire_in & ~|(r_grant & request_in);
`else
    assign w_drop_rel = 1'b0;
`endif
    assign w_release  = (r_state == S_LOCKED) & (w_tail_rel | w_drop_rel);

    // Same-cycle re-arbitration must already see the advanced pointer.
    assign w_arb_ptr  = w_release ? w_rel_ptr : r_ptr;
    assign w_rot      = NUM_ARBITER_PORTS'(rr_rotr(RR_MAX_PORTS'(request_in),
                                                   32'(w_arb_ptr), NUM_ARBITER_PORTS));
    assign w_winner   = NUM_ARBITER_PORTS'(rr_rotl(RR_MAX_PORTS'(w_fpa),
                                                   32'(w_arb_ptr), NUM_ARBITER_PORTS));

    rr_wormhole_arbiter_fpa #(
        .WIDTH (NUM_ARBITER_PORTS)
    ) u_fpa (
        .i_req   (w_rot),
        .o_grant (w_fpa)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (|request_in) begin
                    w_grant_nxt = w_winner;
                    w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (w_release) begin
                    w_ptr_nxt   = w_rel_ptr;
                    w_grant_nxt = w_winner;
                    w_state_nxt = (|request_in) ? S_LOCKED : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_ptr         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= |w_grant_nxt;
            r_ptr         <= w_ptr_nxt;
        end
    end

    assign grant_out       = r_grant;
    assign grant_valid_out = r_grant_valid;
    assign locked_out      = (r_state == S_LOCKED);

endmodule

`default_nettype wire
